// File: rtl/sonar_pkg.sv
// Shared types and defaults for the sonar time-of-flight timer.
package sonar_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int DEB_W_DEF = 4;

    // Value at which the default-width tick counter stops incrementing.
    localparam logic [CNT_W_DEF-1:0] CNT_SAT = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_BLANK,
        ST_LISTEN,
        ST_CONFIRM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sonar_sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear coinciding with an enable restarts the count at 1, so a run
// counter can be seeded with its first hit in a single cycle.
module sonar_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_q;

    // Clear has priority over counting; counting stops at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= en ? ONE : '0;
        end else if (en && (r_q != '1)) begin
            r_q <= r_q + ONE;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sonar_tof_timer.sv
// Echo time-of-flight timer: gates the transmit burst, blanks the receiver,
// then waits for a debounced comparator hit or a timeout. All timing is in
// ce_pcm ticks; tick k=0 is the first ce_pcm after a start is accepted.
module sonar_tof_timer
    import sonar_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int BURST_LEN = 8,
    parameter int DEB_W     = DEB_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce_pcm,
    input  logic             cmp,
    input  logic             start,
    input  logic [CNT_W-1:0] blank_len,
    input  logic [CNT_W-1:0] max_len,
    input  logic [DEB_W-1:0] deb_len,
    output logic             tx_en,
    output logic             busy,
    output logic             done,
    output logic             echo_found,
    output logic             timeout,
    output logic [CNT_W-1:0] tof
);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] BURST_CNT  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W:0]   K_ONE      = (CNT_W+1)'(1);
    localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);
    localparam logic [DEB_W:0]   RUN_ONE    = (DEB_W+1)'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_blank;
    logic [CNT_W-1:0] r_max;
    logic [DEB_W-1:0] r_deb;
    logic [CNT_W-1:0] r_cand;
    logic [CNT_W-1:0] r_tof;
    logic             r_tx_en;
    logic             r_busy;
    logic             r_done;
    logic             r_found;
    logic             r_timeout;

    logic [CNT_W-1:0] w_k;
    logic [DEB_W-1:0] w_run;
    logic             w_k_clr;
    logic             w_k_en;
    logic             w_run_clr;
    logic             w_run_en;
    logic [CNT_W:0]   w_k_inc;
    logic [DEB_W:0]   w_run_inc;
    logic             w_blank_end;
    logic             w_to_hit;
    logic             w_confirm_l;
    logic             w_confirm_c;

    // k restarts on the accepting edge and advances only on ticks of an
    // active measurement, so a ce_pcm coincident with the accept is not counted.
    assign w_k_clr = (r_state == ST_IDLE) && start;
    assign w_k_en  = ce_pcm && ((r_state == ST_TX) || (r_state == ST_BLANK) ||
                                (r_state == ST_LISTEN) || (r_state == ST_CONFIRM));

    // The run counter is seeded to 1 by the first hit in LISTEN and grows in CONFIRM.
    assign w_run_clr = ce_pcm && cmp && (r_state == ST_LISTEN);
    assign w_run_en  = ce_pcm && cmp && (r_state == ST_CONFIRM);

    sonar_sat_counter #(.W(CNT_W)) u_tick_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_k_clr),
        .en  (w_k_en),
        .q   (w_k)
    );

    sonar_sat_counter #(.W(DEB_W)) u_run_cnt (
        .clk (clk),
        .rst (rst),
        .clr (w_run_clr),
        .en  (w_run_clr | w_run_en),
        .q   (w_run)
    );

    // Widened by one bit so k+1 cannot wrap at the saturation value.
    assign w_k_inc     = {1'b0, w_k} + K_ONE;
    assign w_run_inc   = {1'b0, w_run} + RUN_ONE;
    assign w_blank_end = (w_k_inc >= {1'b0, r_blank});
    assign w_to_hit    = (w_k >= r_max);
    assign w_confirm_l = cmp && (r_deb <= DEB_ONE);
    assign w_confirm_c = cmp && (w_run_inc == {1'b0, r_deb});

    // Measurement FSM; echo confirmation is tested before timeout so it wins a tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_blank   <= '0;
            r_max     <= '0;
            r_deb     <= '0;
            r_cand    <= '0;
            r_tof     <= '0;
            r_tx_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_found   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_TX;
                        r_blank   <= blank_len;
                        r_max     <= max_len;
                        r_deb     <= (deb_len == '0) ? DEB_ONE : deb_len;
                        r_found   <= 1'b0;
                        r_timeout <= 1'b0;
                        r_tx_en   <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_TX: begin
                    if (ce_pcm && (w_k == BURST_LAST)) begin
                        r_tx_en <= 1'b0;
                        r_state <= (r_blank > BURST_CNT) ? ST_BLANK : ST_LISTEN;
                    end
                end
                ST_BLANK: begin
                    if (ce_pcm) begin
                        if (w_to_hit) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_timeout <= 1'b1;
                            r_tof     <= w_k;
                        end else if (w_blank_end) begin
                            r_state <= ST_LISTEN;
                        end
                    end
                end
                ST_LISTEN: begin
                    if (ce_pcm) begin
                        if (w_confirm_l) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_found <= 1'b1;
                            r_tof   <= w_k;
                        end else if (w_to_hit) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_timeout <= 1'b1;
                            r_tof     <= w_k;
                        end else if (cmp) begin
                            r_cand  <= w_k;
                            r_state <= ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (ce_pcm) begin
                        if (w_confirm_c) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_found <= 1'b1;
                            r_tof   <= r_cand;
                        end else if (w_to_hit) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_timeout <= 1'b1;
                            r_tof     <= w_k;
                        end else if (!cmp) begin
                            r_state <= ST_LISTEN;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_en      = r_tx_en;
    assign busy       = r_busy;
    assign done       = r_done;
    assign echo_found = r_found;
    assign timeout    = r_timeout;
    assign tof        = r_tof;

endmodule

// File: tb/tb_sonar_tof_timer.sv
// Directed bench for sonar_tof_timer: echo, glitch, blanking, timeout,
// tie-break, busy-start and mid-measurement reset scenarios.
module tb_sonar_tof_timer;

    localparam int CNT_W     = 16;
    localparam int DEB_W     = 4;
    localparam int BURST_LEN = 8;
    localparam int NEVER     = 100000;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce_pcm;
    logic             cmp;
    logic             start;
    logic [CNT_W-1:0] blank_len;
    logic [CNT_W-1:0] max_len;
    logic [DEB_W-1:0] deb_len;
    logic             tx_en;
    logic             busy;
    logic             done;
    logic             echo_found;
    logic             timeout;
    logic [CNT_W-1:0] tof;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         blank;
        int         maxl;
        int         deb;
        int         a0;
        int         a1;
        int         b0;
        int         done_t;
        int         tof;
        logic [1:0] flags;
    } vec_t;

    sonar_tof_timer #(.CNT_W(CNT_W), .BURST_LEN(BURST_LEN), .DEB_W(DEB_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_pcm     (ce_pcm),
        .cmp        (cmp),
        .start      (start),
        .blank_len  (blank_len),
        .max_len    (max_len),
        .deb_len    (deb_len),
        .tx_en      (tx_en),
        .busy       (busy),
        .done       (done),
        .echo_found (echo_found),
        .timeout    (timeout),
        .tof        (tof)
    );

    always #5 clk = ~clk;

    // One idle clk followed by one ce_pcm clk; d reports done seen after the tick edge.
    task automatic tick(input logic c, output logic d);
        @(posedge clk); #1;
        ce_pcm = 1'b1;
        cmp    = c;
        @(posedge clk); #1;
        ce_pcm = 1'b0;
        cmp    = 1'b0;
        d      = done;
    endtask

    // Accept a start, then scramble the config inputs so only latched values matter.
    task automatic start_meas(input int blank, input int maxl, input int deb);
        blank_len = CNT_W'(blank);
        max_len   = CNT_W'(maxl);
        deb_len   = DEB_W'(deb);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        blank_len = '1;
        max_len   = CNT_W'(1);
        deb_len   = DEB_W'(1);
    endtask

    // Runs one measurement with cmp high on ticks [a0,a1] and from b0 on.
    // Holds start high through the done cycle and reports busy/done one clk later.
    task automatic measure(input vec_t v, output int done_t, output logic [CNT_W-1:0] tof_o,
                           output logic [1:0] flags, output int tx_bad, output logic [1:0] after);
        logic d;
        logic c;
        done_t = -1;
        tx_bad = 0;
        start_meas(v.blank, v.maxl, v.deb);
        for (int t = 0; t < 1200; t++) begin
            if (tx_en !== (t < BURST_LEN)) tx_bad++;
            c = ((t >= v.a0) && (t <= v.a1)) || (t >= v.b0);
            tick(c, d);
            if (d) begin
                done_t = t;
                break;
            end
        end
        tof_o = tof;
        flags = {echo_found, timeout};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        after = {busy, done};
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        ce_pcm    = 1'b1;
        cmp       = 1'b1;
        start     = 1'b1;
        blank_len = 16'd5;
        max_len   = 16'd5;
        deb_len   = 4'd1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({tx_en, busy, done, echo_found, timeout} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 00000", {tx_en, busy, done, echo_found, timeout});
        end
        n_vec++;
        if (tof !== '0) begin
            n_err++;
            $display("FAIL reset_tof: got %0d want 0", tof);
        end
        ce_pcm = 1'b0;
        cmp    = 1'b0;
        start  = 1'b0;
        rst    = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_echo();
        vec_t tab[4];
        int done_t, tx_bad;
        logic [CNT_W-1:0] tof_o;
        logic [1:0] flags, after;
        tab[0] = '{20, 1000, 3, -1, -2, 50,    52, 50, 2'b10};  // plain echo
        tab[1] = '{20, 1000, 3, 30, 31, 60,    62, 60, 2'b10};  // 2-tick glitch rejected
        tab[2] = '{20, 1000, 3,  0, 25, NEVER, 22, 20, 2'b10};  // blanked hits ignored
        tab[3] = '{ 4, 1000, 0, -1, -2, 8,      8,  8, 2'b10};  // short blank, deb 0
        for (int i = 0; i < 4; i++) begin
            measure(tab[i], done_t, tof_o, flags, tx_bad, after);
            n_vec++;
            if (done_t !== tab[i].done_t) begin
                n_err++;
                $display("FAIL echo[%0d]_done_tick: got %0d want %0d", i, done_t, tab[i].done_t);
            end
            n_vec++;
            if (tof_o !== CNT_W'(tab[i].tof)) begin
                n_err++;
                $display("FAIL echo[%0d]_tof: got %0d want %0d", i, tof_o, tab[i].tof);
            end
            n_vec++;
            if (flags !== tab[i].flags) begin
                n_err++;
                $display("FAIL echo[%0d]_found_timeout: got %b want %b", i, flags, tab[i].flags);
            end
            n_vec++;
            if (tx_bad !== 0) begin
                n_err++;
                $display("FAIL echo[%0d]_tx_en: %0d ticks wrong, want 0", i, tx_bad);
            end
            n_vec++;
            if (after !== 2'b00) begin
                n_err++;
                $display("FAIL echo[%0d]_busy_done_after: got %b want 00", i, after);
            end
        end
    endtask

    task automatic test_timeout();
        vec_t tab[3];
        int done_t, tx_bad;
        logic [CNT_W-1:0] tof_o;
        logic [1:0] flags, after;
        tab[0] = '{20, 100, 3, -1, -2, NEVER, 100, 100, 2'b01};  // silence
        tab[1] = '{20,  52, 3, -1, -2, 50,     52,  50, 2'b10};  // tie: echo wins
        tab[2] = '{20,  51, 3, -1, -2, 50,     51,  51, 2'b01};  // timeout inside CONFIRM
        for (int i = 0; i < 3; i++) begin
            measure(tab[i], done_t, tof_o, flags, tx_bad, after);
            n_vec++;
            if (done_t !== tab[i].done_t) begin
                n_err++;
                $display("FAIL timeout[%0d]_done_tick: got %0d want %0d", i, done_t, tab[i].done_t);
            end
            n_vec++;
            if (tof_o !== CNT_W'(tab[i].tof)) begin
                n_err++;
                $display("FAIL timeout[%0d]_tof: got %0d want %0d", i, tof_o, tab[i].tof);
            end
            n_vec++;
            if (flags !== tab[i].flags) begin
                n_err++;
                $display("FAIL timeout[%0d]_found_timeout: got %b want %b", i, flags, tab[i].flags);
            end
            n_vec++;
            if (tx_bad !== 0) begin
                n_err++;
                $display("FAIL timeout[%0d]_tx_en: %0d ticks wrong, want 0", i, tx_bad);
            end
            n_vec++;
            if (after !== 2'b00) begin
                n_err++;
                $display("FAIL timeout[%0d]_busy_done_after: got %b want 00", i, after);
            end
        end
    endtask

    task automatic test_control();
        logic d;
        logic seen;
        int done_t, tx_bad;
        logic [CNT_W-1:0] tof_o;
        logic [1:0] flags, after;
        vec_t v;
        seen = 1'b0;
        start_meas(20, 1000, 3);
        for (int t = 0; t < 25; t++) begin
            tick(1'b0, d);
            seen |= d;
        end
        start = 1'b1;                       // re-pulse while listening
        tick(1'b0, d);
        seen |= d;
        start = 1'b0;
        n_vec++;
        if ({tx_en, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL ctrl_busy_start: tx_en/busy got %b want 01", {tx_en, busy});
        end
        for (int t = 26; t < 40; t++) begin
            tick(1'b0, d);
            seen |= d;
        end
        tick(1'b1, d);                      // tick 40: enter CONFIRM
        seen |= d;
        tick(1'b1, d);                      // tick 41: run = 2
        seen |= d;
        n_vec++;
        if ({seen, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL ctrl_pre_reset: done_seen/busy got %b want 01", {seen, busy});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({tx_en, busy, done, echo_found, timeout} !== 5'b0 || tof !== '0) begin
            n_err++;
            $display("FAIL ctrl_abort_reset: flags %b tof %0d want 00000 / 0",
                     {tx_en, busy, done, echo_found, timeout}, tof);
        end
        rst  = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            tick(1'b1, d);
            seen |= d;
        end
        n_vec++;
        if ({seen, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL ctrl_no_done_after_reset: done_seen/busy got %b want 00", {seen, busy});
        end
        v = '{10, 1000, 2, -1, -2, 15, 16, 15, 2'b10};
        measure(v, done_t, tof_o, flags, tx_bad, after);
        n_vec++;
        if (done_t !== 16 || tof_o !== 16'd15) begin
            n_err++;
            $display("FAIL ctrl_fresh_meas: done tick %0d tof %0d want 16 / 15", done_t, tof_o);
        end
        n_vec++;
        if ({flags, after} !== 4'b1000 || tx_bad !== 0) begin
            n_err++;
            $display("FAIL ctrl_fresh_flags: found/timeout/busy/done %b tx_bad %0d want 1000 / 0",
                     {flags, after}, tx_bad);
        end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_timeout();
        test_control();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
